// File: rtl/tile_renderer_if.sv
// tile_renderer_if: tile-map write port between game logic and tile_renderer.
// Signals:
//   wr_valid  requester has a tile write pending
//   wr_ready  renderer accepts the write this cycle
//   wr_x      target tile column (0..19 valid, larger is accepted and dropped)
//   wr_y      target tile row    (0..14 valid, larger is accepted and dropped)
//   wr_tile   4-bit tile code to store
// Modports: master = game logic, slave = tile_renderer.
interface tile_renderer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_x;
  logic [3:0] wr_y;
  logic [3:0] wr_tile;

  modport master (
    output wr_valid, wr_x, wr_y, wr_tile,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_tile,
    output wr_ready
  );
endinterface

// File: rtl/tile_renderer.sv
// tile_renderer: 3-stage pixel pipeline behind VGA_controller. Renders a
// 20x15 map of 32x32 tiles through a fixed palette with a cursor outline,
// and delays the syncs to stay aligned with rgb.
// Ports:
//   clock, reset                  pixel clock, async active-high reset
//   display_enable, row, column   current pixel from VGA_controller
//   h_sync, v_sync                active-low syncs from VGA_controller
//   wr                            tile write port (tile_renderer_if.slave)
//   cursor_x, cursor_y            cursor tile coordinates
//   rgb                           pixel colour R[7:5] G[4:2] B[1:0]
//   h_sync_out, v_sync_out        syncs delayed 3 clocks
//   frame_count                   v_sync falling edges seen, wraps at 255
// Optional feature: define TILE_RENDERER_CURSOR_BLINK_EN to blink the cursor
// outline with frame_count[5] (drawn while it is 0).
module tile_renderer #(
  parameter int unsigned MAP_COLS     = 20,
  parameter int unsigned MAP_ROWS     = 15,
  parameter logic [7:0]  CURSOR_COLOR = 8'hFF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             display_enable,
  input  logic [15:0]      row,
  input  logic [15:0]      column,
  input  logic             h_sync,
  input  logic             v_sync,
  tile_renderer_if.slave   wr,
  input  logic [4:0]       cursor_x,
  input  logic [3:0]       cursor_y,
  output logic [7:0]       rgb,
  output logic             h_sync_out,
  output logic             v_sync_out,
  output logic [7:0]       frame_count
);

  localparam int unsigned MAP_SIZE = MAP_COLS * MAP_ROWS;
  localparam int unsigned ADDR_W   = $clog2(MAP_SIZE);
  localparam int unsigned TILE_W   = 4;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_idx;
  logic [TILE_W-1:0]   map [MAP_SIZE];

  // S1 / S2 pipeline registers
  logic [ADDR_W-1:0]   s1_addr;
  logic                s1_vis, s1_cursor;
  logic                s2_vis, s2_cursor;
  logic [TILE_W-1:0]   s2_tile;
  logic [1:0]          hs_pipe, vs_pipe;
  logic                vs_prev;

  // Pixel decode for S1
  logic                in_map_c, cursor_hit_c, cursor_on_c;
  logic [ADDR_W-1:0]   pix_addr_c;
  assign in_map_c   = (column < 16'(MAP_COLS * 32)) && (row < 16'(MAP_ROWS * 32));
  assign pix_addr_c = ADDR_W'(row[15:5]) * ADDR_W'(MAP_COLS) + ADDR_W'(column[15:5]);
  // Outline = in-tile offset 0, 1, 30 or 31, i.e. offset[4:1] all-zero or all-one
  assign cursor_hit_c = (column[15:5] == 11'(cursor_x)) && (row[15:5] == 11'(cursor_y)) &&
                        ((column[4:1] == 4'h0) || (column[4:1] == 4'hF) ||
                         (row[4:1] == 4'h0)    || (row[4:1] == 4'hF));

`ifdef TILE_RENDERER_CURSOR_BLINK_EN
  assign cursor_on_c = s2_cursor && !frame_count[5];
`else
  assign cursor_on_c = s2_cursor;
`endif

  // Map write port: CLEAR sweep has priority, otherwise in-range transfers
  logic                map_we_c;
  logic [ADDR_W-1:0]   map_waddr_c, wr_addr_c;
  logic [TILE_W-1:0]   map_wdata_c;
  logic                wr_in_range_c;
  assign wr_addr_c     = ADDR_W'(wr.wr_y) * ADDR_W'(MAP_COLS) + ADDR_W'(wr.wr_x);
  assign wr_in_range_c = (wr.wr_x < 5'(MAP_COLS)) && (wr.wr_y < 4'(MAP_ROWS));

  always_comb begin
    map_we_c    = 1'b0;
    map_waddr_c = wr_addr_c;
    map_wdata_c = wr.wr_tile;
    if (state == CLEAR) begin
      map_we_c    = 1'b1;
      map_waddr_c = clr_idx;
      map_wdata_c = '0;
    end else if (wr.wr_valid && wr.wr_ready && wr_in_range_c) begin
      map_we_c = 1'b1;
    end
  end

  // Map storage; the read samples before the write lands (read-old on collision)
  always_ff @(posedge clock) begin
    if (map_we_c) map[map_waddr_c] <= map_wdata_c;
    s2_tile <= map[s1_addr];
  end

  function automatic logic [7:0] palette(input logic [TILE_W-1:0] code);
    case (code)
      4'd0:    palette = 8'h00;
      4'd1:    palette = 8'hE0;
      4'd2:    palette = 8'h1C;
      4'd3:    palette = 8'h03;
      4'd4:    palette = 8'hFC;
      default: palette = 8'h92;
    endcase
  endfunction

  // Control FSM, pixel pipeline, sync delay and frame counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= CLEAR;
      clr_idx     <= '0;
      wr.wr_ready <= 1'b0;
      s1_addr     <= '0;
      s1_vis      <= 1'b0;
      s1_cursor   <= 1'b0;
      s2_vis      <= 1'b0;
      s2_cursor   <= 1'b0;
      rgb         <= 8'h00;
      hs_pipe     <= 2'b11;
      vs_pipe     <= 2'b11;
      h_sync_out  <= 1'b1;
      v_sync_out  <= 1'b1;
      vs_prev     <= 1'b1;
      frame_count <= 8'h00;
    end else begin
      case (state)
        CLEAR: begin
          wr.wr_ready <= 1'b0;
          clr_idx     <= clr_idx + 1'b1;
          if (clr_idx == ADDR_W'(MAP_SIZE - 1)) state <= RUN;
        end
        RUN: begin
          wr.wr_ready <= !display_enable;
        end
        default: state <= CLEAR;
      endcase

      s1_addr   <= in_map_c ? pix_addr_c : '0;
      s1_vis    <= display_enable && in_map_c;
      s1_cursor <= cursor_hit_c;

      s2_vis    <= s1_vis;
      s2_cursor <= s1_cursor;

      if ((state == RUN) && s2_vis) rgb <= cursor_on_c ? CURSOR_COLOR : palette(s2_tile);
      else                          rgb <= 8'h00;

      hs_pipe    <= {hs_pipe[0], h_sync};
      vs_pipe    <= {vs_pipe[0], v_sync};
      h_sync_out <= hs_pipe[1];
      v_sync_out <= vs_pipe[1];

      vs_prev <= v_sync;
      if (vs_prev && !v_sync) frame_count <= frame_count + 8'd1;
    end
  end

endmodule
